regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port (dest/write_enable/data_in) between two
//  writeback requesters (req0 = ALU, req1 = load unit). Each requester owns a small FIFO;
//  a round-robin arbiter drains the FIFOs into the register file. Per-register pending
//  counters feed decode a pending_mask for RAW/WAW stalls. Sits between EX/MEM and ID.
// PARAMETERS
//  XLEN        32  data width, equal to the register file width
//  ADDR_W      3   register address width; NREG = 1<<ADDR_W (localparam)
//  FIFO_DEPTH  2   entries per requester FIFO, >=1
// PORTS
//  clk                 in   1       single clock, rising edge
//  reset               in   1       synchronous, active-high
//  req0_valid          in   1       req0 offers a write
//  req0_ready          out  1       req0 FIFO can accept
//  req0_dest           in   ADDR_W  req0 destination register
//  req0_data           in   XLEN    req0 write data
//  req1_valid/ready/dest/data       as req0, for requester 1
//  rf_dest             out  ADDR_W  to register file dest
//  rf_write_enable     out  1       to register file write_enable
//  rf_data_in          out  XLEN    to register file data_in
//  pending_mask        out  NREG    bit r = writes to r accepted but not yet committed
//  idle                out  1       both FIFOs empty
// BEHAVIOUR
//  - Reset (sync): FIFOs emptied, pending counters 0, last_grant=1 (req0 wins first).
//    While reset is high: reqN_ready=0, rf_write_enable=0, rf_dest=0, rf_data_in=0,
//    pending_mask=0, idle=1. Queued entries are dropped, never written.
//  - Accept: reqN_valid && reqN_ready at a rising edge pushes {dest,data}.
//    reqN_ready = !reset && (countN < FIFO_DEPTH); no same-cycle pop credit.
//  - Arbitration (combinational from FIFO heads): neither non-empty -> no grant; one
//    non-empty -> grant it; both -> grant the one != last_grant. last_grant updates
//    only on a grant.
//  - Commit: rf_write_enable=1 in a granted cycle, rf_dest/rf_data_in = granted head;
//    the register file write and FIFO pop occur at the same edge. No grant -> outputs 0.
//  - Latency: accept at edge E0 -> rf_write_enable high in cycle after E0 at earliest
//    (committed at E1). Max 1 commit/cycle; both requesters streaming -> each gets 1/2.
//  - Ordering: FIFO order within a requester. No order is guaranteed across requesters;
//    decode stalls on pending_mask to keep program order.
//  - Pending counters: one per register, width clog2(2*FIFO_DEPTH+1). Each cycle
//    cnt[r] += (acc0 && dest0==r) + (acc1 && dest1==r) - (commit && rf_dest==r).
//    Simultaneous accept and commit to the same r -> count unchanged, bit stays 1.
//    Two accepts to the same r in one cycle -> +2. pending_mask[r] = (cnt[r] != 0).
//    Counters never underflow or overflow by construction; sim assertion on both.
//  - pending_mask and idle are registered state (counters/FIFO counts), not functions
//    of the current-cycle valid inputs.
//  - Reg 0 has no special handling; the write is forwarded like any other.
// STRUCTURE
//  - Shared package regfile_pkg: XLEN, ADDR_W, NREG, wb_entry_t {dest, data}.
//  - Sub-module wb_fifo (synchronous FIFO: push/pop/full/empty/head, depth param),
//    instantiated twice. Arbiter, grant pointer and pending counters live at top level.
// TESTING
//  1. After reset, req0 dest=3 data=0xDEADBEEF for 1 cycle -> next cycle rf_write_enable=1,
//     rf_dest=3, rf_data_in=0xDEADBEEF, pending_mask=0x08; following cycle mask=0x00, idle=1.
//  2. Both valid every cycle, req0 dest=1, req1 dest=2 -> commits alternate 1,2,1,2,
//     req0 first.
//  3. Both valid, dest 4/5, 6 cycles -> FIFOs reach 2, readyN toggles so each side gets
//     one accept per 2 cycles; no entry lost or duplicated (scoreboard check).
//  4. req0 and req1 both dest=5 in the same cycle -> cnt[5]=2; mask bit 5 stays 1 across
//     the first commit and clears only after the second.
//  5. req0 dest=7 accepted in the same cycle a queued dest=7 commits -> pending_mask[7]
//     stays 1, then clears after the final commit.
//  6. 3 entries queued, reset pulsed 1 cycle -> cycle after: idle=1, pending_mask=0, no
//     rf_write_enable until new accepts arrive.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file writeback arbiter.
// A queued writeback entry is {dest, data} and is carried as a flat vector on ports.
package regfile_pkg;

    localparam int XLEN    = 32;
    localparam int ADDR_W  = 3;
    localparam int NREG    = 1 << ADDR_W;
    localparam int ENTRY_W = ADDR_W + XLEN;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding pending writeback entries for one requester.
// Push is ignored when full and pop when empty; head_o is the oldest entry.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_data_i,
    input  logic               pop_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage needs no reset: entries are only visible through the count.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register file write port between the ALU (req0) and the
// load unit (req1), with per-register pending counters that drive decode stalls.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_dest,
    input  logic [XLEN-1:0]   req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_dest,
    input  logic [XLEN-1:0]   req1_data,
    output logic [ADDR_W-1:0] rf_dest,
    output logic              rf_write_enable,
    output logic [XLEN-1:0]   rf_data_in,
    output logic [NREG-1:0]   pending_mask,
    output logic              idle
);

    localparam int CNT_W = $clog2(2 * FIFO_DEPTH + 1);

    // Handshake: a request transfers at a rising edge where valid && ready are both 1.
    // ready depends only on the FIFO fill level (no same-cycle pop credit) and reset.
    logic         acc0, acc1, full0, full1, empty0, empty1;
    logic         gnt0, gnt1, commit;
    logic         last_grant_q;
    wb_entry_t    head0, head1, win;
    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [1:0]       inc_w [NREG];
    logic             dec_w [NREG];
    logic [NREG-1:0]  mask_w;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk         (clk),
        .reset       (reset),
        .push_i      (acc0),
        .push_data_i ({req0_dest, req0_data}),
        .pop_i       (gnt0 && !reset),
        .head_o      (head0),
        .full_o      (full0),
        .empty_o     (empty0)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk         (clk),
        .reset       (reset),
        .push_i      (acc1),
        .push_data_i ({req1_dest, req1_data}),
        .pop_i       (gnt1 && !reset),
        .head_o      (head1),
        .full_o      (full1),
        .empty_o     (empty1)
    );

    assign req0_ready = !reset && !full0;
    assign req1_ready = !reset && !full1;
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;

    // last_grant_q = 1 means req1 was granted last, so req0 wins the next tie.
    assign gnt0   = !empty0 && (empty1 || last_grant_q);
    assign gnt1   = !empty1 && (empty0 || !last_grant_q);
    assign commit = !reset && (gnt0 || gnt1);
    assign win    = gnt0 ? head0 : head1;

    assign rf_write_enable = commit;
    assign rf_dest         = commit ? win.dest : '0;
    assign rf_data_in      = commit ? win.data : '0;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            inc_w[r] = 2'(acc0 && (req0_dest == ADDR_W'(r)))
                     + 2'(acc1 && (req1_dest == ADDR_W'(r)));
            dec_w[r] = commit && (win.dest == ADDR_W'(r));
            cnt_d[r] = cnt_q[r] + CNT_W'(inc_w[r]) - CNT_W'(dec_w[r]);
            mask_w[r] = (cnt_q[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            cnt_q        <= '{default: '0};
        end else begin
            if (commit) last_grant_q <= gnt1;
            cnt_q <= cnt_d;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                assert (!(dec_w[r] && cnt_q[r] == '0 && inc_w[r] == 2'd0));
                assert (int'(cnt_q[r]) + int'(inc_w[r]) - int'(dec_w[r]) <= 2 * FIFO_DEPTH);
            end
        end
    end
`endif

    assign pending_mask = reset ? '0 : mask_w;
    assign idle         = reset || (empty0 && empty1);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random stimulus for regfile_wb_arbiter, checked against per-requester
// expected queues and a reference round-robin pointer.
module tb_regfile_wb_arbiter;

    localparam int FIFO_DEPTH = 2;
    localparam int AW = 3;
    localparam int XW = 32;
    localparam int W  = AW + XW;
    localparam int NR = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] req0_dest, req1_dest;
    logic [XW-1:0] req0_data, req1_data;
    logic [AW-1:0] rf_dest;
    logic          rf_write_enable;
    logic [XW-1:0] rf_data_in;
    logic [NR-1:0] pending_mask;
    logic          idle;

    logic [W-1:0]  exp0_q[$];
    logic [W-1:0]  exp1_q[$];
    logic          lg_m;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .req0_valid      (req0_valid),
        .req0_ready      (req0_ready),
        .req0_dest       (req0_dest),
        .req0_data       (req0_data),
        .req1_valid      (req1_valid),
        .req1_ready      (req1_ready),
        .req1_dest       (req1_dest),
        .req1_data       (req1_data),
        .rf_dest         (rf_dest),
        .rf_write_enable (rf_write_enable),
        .rf_data_in      (rf_data_in),
        .pending_mask    (pending_mask),
        .idle            (idle)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare DUT outputs with the reference, then advance the reference by one edge.
    task automatic model_step(input logic rst, input logic v0, input logic [W-1:0] e0,
                              input logic v1, input logic [W-1:0] e1);
        logic          r0, r1, g0, g1;
        logic [W-1:0]  exp_e;
        logic [NR-1:0] m;
        logic [AW-1:0] d;
        r0 = !rst && (exp0_q.size() < FIFO_DEPTH);
        r1 = !rst && (exp1_q.size() < FIFO_DEPTH);
        g0 = !rst && exp0_q.size() > 0 && (exp1_q.size() == 0 || lg_m);
        g1 = !rst && exp1_q.size() > 0 && (exp0_q.size() == 0 || !lg_m);
        exp_e = '0;
        if (g0) exp_e = exp0_q[0];
        if (g1) exp_e = exp1_q[0];
        m = '0;
        if (!rst) begin
            for (int i = 0; i < exp0_q.size(); i++) begin d = exp0_q[i][W-1 -: AW]; m[d] = 1'b1; end
            for (int i = 0; i < exp1_q.size(); i++) begin d = exp1_q[i][W-1 -: AW]; m[d] = 1'b1; end
        end
        chk("ready0", req0_ready, r0);
        chk("ready1", req1_ready, r1);
        chk("wr_en", rf_write_enable, g0 || g1);
        chk("commit", {rf_dest, rf_data_in}, exp_e);
        chk("mask", pending_mask, m);
        chk("idle", idle, rst || (exp0_q.size() == 0 && exp1_q.size() == 0));
        if (rst) begin
            exp0_q.delete();
            exp1_q.delete();
            lg_m = 1'b1;
        end else begin
            if (g0) begin void'(exp0_q.pop_front()); lg_m = 1'b0; end
            if (g1) begin void'(exp1_q.pop_front()); lg_m = 1'b1; end
            if (v0 && r0) exp0_q.push_back(e0);
            if (v1 && r1) exp1_q.push_back(e1);
        end
    endtask

    task automatic cycle(input logic rst,
                         input logic v0, input logic [AW-1:0] d0, input logic [XW-1:0] x0,
                         input logic v1, input logic [AW-1:0] d1, input logic [XW-1:0] x1);
        reset      = rst;
        req0_valid = v0; req0_dest = d0; req0_data = x0;
        req1_valid = v1; req1_dest = d1; req1_data = x1;
        @(negedge clk);
        model_step(rst, v0, {d0, x0}, v1, {d1, x1});
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic reset_cycle();
        cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && !(exp0_q.size() == 0 && exp1_q.size() == 0); i++) idle_cycle();
        chk(tag, idle, 1'b1);
    endtask

    initial begin
        lg_m = 1'b1;
        reset = 1'b1;
        req0_valid = 1'b0; req0_dest = '0; req0_data = '0;
        req1_valid = 1'b0; req1_dest = '0; req1_data = '0;
        #1;
        chk("rst_idle", idle, 1'b1);
        chk("rst_mask", pending_mask, 8'h00);
        chk("rst_we", rf_write_enable, 1'b0);
        repeat (3) reset_cycle();

        // Single write from req0 commits one cycle after acceptance.
        cycle(1'b0, 1'b1, 3'd3, 32'hDEADBEEF, 1'b0, '0, '0);
        chk("t1_we", rf_write_enable, 1'b1);
        chk("t1_dest", rf_dest, 3'd3);
        chk("t1_data", rf_data_in, 32'hDEADBEEF);
        chk("t1_mask", pending_mask, 8'h08);
        idle_cycle();
        chk("t1_mask_clr", pending_mask, 8'h00);
        chk("t1_idle", idle, 1'b1);

        // Both streaming: commits alternate starting with req0.
        reset_cycle();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 3'd1, 32'(i), 1'b1, 3'd2, 32'(100 + i));
            if (i > 0) chk("t2_order", rf_dest, (i % 2 == 1) ? 3'd2 : 3'd1);
        end
        drain("t2_drain");

        // FIFOs fill and readiness alternates between the requesters.
        reset_cycle();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 3'd4, $urandom, 1'b1, 3'd5, $urandom);
            if (i == 2) begin
                chk("t3_ready0", req0_ready, 1'b0);
                chk("t3_ready1", req1_ready, 1'b1);
            end
        end
        drain("t3_drain");

        // Two accepts to the same register in one cycle.
        reset_cycle();
        cycle(1'b0, 1'b1, 3'd5, 32'h5A5A0000, 1'b1, 3'd5, 32'h5A5A0001);
        chk("t4_mask2", pending_mask, 8'h20);
        idle_cycle();
        chk("t4_mask1", pending_mask, 8'h20);
        idle_cycle();
        chk("t4_mask0", pending_mask, 8'h00);
        chk("t4_idle", idle, 1'b1);

        // Accept and commit to the same register in one cycle.
        reset_cycle();
        cycle(1'b0, 1'b1, 3'd7, 32'h77770000, 1'b0, '0, '0);
        chk("t5_mask_a", pending_mask, 8'h80);
        cycle(1'b0, 1'b1, 3'd7, 32'h77770001, 1'b0, '0, '0);
        chk("t5_mask_b", pending_mask, 8'h80);
        idle_cycle();
        chk("t5_mask_c", pending_mask, 8'h00);

        // Reset with entries queued drops them.
        reset_cycle();
        cycle(1'b0, 1'b1, 3'd1, 32'h11, 1'b1, 3'd2, 32'h22);
        cycle(1'b0, 1'b1, 3'd3, 32'h33, 1'b1, 3'd4, 32'h44);
        chk("t6_busy", idle, 1'b0);
        reset_cycle();
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("t6_idle", idle, 1'b1);
        chk("t6_mask", pending_mask, 8'h00);
        chk("t6_we", rf_write_enable, 1'b0);
        idle_cycle();
        chk("t6_we_quiet", rf_write_enable, 1'b0);
        cycle(1'b0, 1'b1, 3'd6, 32'h66, 1'b0, '0, '0);
        chk("t6_new_we", rf_write_enable, 1'b1);
        chk("t6_new_dest", rf_dest, 3'd6);
        drain("t6_drain");

        // Random traffic with occasional reset.
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 39) == 0,
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, NR - 1)), $urandom,
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, NR - 1)), $urandom);
        end
        drain("rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
